// File: rtl/myo_spi_pkg.sv
// Shared definitions for the myocontrol SPI responder.
//   spi_state_t      : responder FSM states
//   WORD_BITS_DEF    : default bits per SPI word
//   MYO_FRAME_WORDS  : words in a complete myocontrol frame
package myo_spi_pkg;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    localparam int WORD_BITS_DEF   = 16;
    localparam int MYO_FRAME_WORDS = 12;

endpackage

// File: rtl/spi_input_sync.sv
// Three-flop synchroniser for one asynchronous SPI pin.
//   clock   in  : system clock
//   reset_n in  : async active-low reset (all flops clear to 0)
//   din     in  : asynchronous pin
//   q       out : synchronised level (second flop)
//   rise    out : one-cycle pulse on a synchronised 0->1 transition
//   fall    out : one-cycle pulse on a synchronised 1->0 transition
module spi_input_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Clearing to 0 matters for ss_n: after reset the responder only leaves
    // ARM once a genuine high level has propagated through.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/myo_spi_responder.sv
// SPI mode-0 slave emulating one motor-board endpoint of the myocontrol link.
// Receives command words MSB first, streams one reply word per slot from the
// parent's register file and flags frame completion / framing errors.
//   clock, reset_n     : system clock, async active-low reset
//   sck, ss_n, mosi    : SPI inputs, asynchronous to clock
//   miso, miso_oe      : reply data and its drive enable
//   tx_index / tx_word : reply slot request / reply word from parent
//   rx_word, rx_index  : last complete word and its slot, qualified by rx_valid
//   frame_done         : pulse, frame closed after exactly FRAME_WORDS words
//   frame_error        : pulse, frame closed mid-word or with a wrong word count
//   busy               : high while a frame is being shifted
//
// state    | meaning
// ARM      | wait for ss_n high so a frame cut by reset is never decoded
// IDLE     | bus released, tx_index parked at 0, waiting for ss_n fall
// SHIFT    | frame in progress, shifting on sck edges until ss_n rises
module myo_spi_responder
    import myo_spi_pkg::*;
#(
    parameter int WORD_BITS   = WORD_BITS_DEF,
    parameter int FRAME_WORDS = MYO_FRAME_WORDS,
    parameter int IDX_W       = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 sck,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic [IDX_W-1:0]     tx_index,
    input  logic [WORD_BITS-1:0] tx_word,
    output logic [WORD_BITS-1:0] rx_word,
    output logic [IDX_W-1:0]     rx_index,
    output logic                 rx_valid,
    output logic                 frame_done,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_BITS - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(FRAME_WORDS);

    logic sck_s, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_input_sync u_sync_sck (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (sck),
        .q       (sck_s),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    spi_input_sync u_sync_ss (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (ss_n),
        .q       (ss_s),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    spi_input_sync u_sync_mosi (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (mosi),
        .q       (mosi_s),
        .rise    (mosi_rise),
        .fall    (mosi_fall)
    );

    // Only the synchronised mosi level is used; its edges and the sck level
    // are intentionally left dangling.
    logic unused_sync;
    assign unused_sync = &{1'b0, sck_s, mosi_rise, mosi_fall};

    spi_state_t           state_q, state_d;
    logic [WORD_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [WORD_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     word_idx_q, word_idx_d;
    logic                 overrun_q, overrun_d;
    logic                 miso_q, miso_d;
    logic                 miso_oe_q, miso_oe_d;
    logic [IDX_W-1:0]     tx_index_q, tx_index_d;
    logic [WORD_BITS-1:0] rx_word_q, rx_word_d;
    logic [IDX_W-1:0]     rx_index_q, rx_index_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_error_q, frame_error_d;
    logic                 busy_q, busy_d;

    logic [WORD_BITS-1:0] rx_next;
    assign rx_next = {rx_shift_q[WORD_BITS-2:0], mosi_s};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ARM;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            word_idx_q    <= '0;
            overrun_q     <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            tx_index_q    <= '0;
            rx_word_q     <= '0;
            rx_index_q    <= '0;
            rx_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_idx_q    <= word_idx_d;
            overrun_q     <= overrun_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            tx_index_q    <= tx_index_d;
            rx_word_q     <= rx_word_d;
            rx_index_q    <= rx_index_d;
            rx_valid_q    <= rx_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        bit_cnt_d     = bit_cnt_q;
        word_idx_d    = word_idx_q;
        overrun_d     = overrun_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        tx_index_d    = tx_index_q;
        rx_word_d     = rx_word_q;
        rx_index_d    = rx_index_q;
        rx_valid_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        busy_d        = busy_q;

        case (state_q)
            ST_ARM: begin
                if (ss_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                tx_index_d = '0;
                if (ss_fall) begin
                    tx_shift_d = tx_word;
                    miso_d     = tx_word[WORD_BITS-1];
                    miso_oe_d  = 1'b1;
                    bit_cnt_d  = '0;
                    word_idx_d = '0;
                    overrun_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                miso_d = tx_shift_q[WORD_BITS-1];
                // ss_n rise takes priority over any sck edge seen in the same cycle.
                if (ss_rise) begin
                    if (bit_cnt_q == '0 && word_idx_q == WORD_LAST && !overrun_q) begin
                        frame_done_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                    miso_oe_d  = 1'b0;
                    miso_d     = 1'b0;
                    busy_d     = 1'b0;
                    tx_index_d = '0;
                    state_d    = ST_IDLE;
                end else if (sck_rise) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (word_idx_q < WORD_LAST) begin
                            rx_word_d  = rx_next;
                            rx_index_d = word_idx_q;
                            rx_valid_d = 1'b1;
                            word_idx_d = word_idx_q + 1'b1;
                        end else begin
                            // word_idx is saturated, so a separate flag records
                            // that the frame ran past its length.
                            overrun_d = 1'b1;
                        end
                        tx_index_d = word_idx_q + 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    // First fall after a completed word: tx_index has been
                    // stable since the preceding rise, so tx_word is settled.
                    if (bit_cnt_q == '0 && word_idx_q != '0) begin
                        tx_shift_d = (word_idx_q < WORD_LAST) ? tx_word : '0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end

            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_index    = tx_index_q;
    assign rx_word     = rx_word_q;
    assign rx_index    = rx_index_q;
    assign rx_valid    = rx_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_myo_spi_responder.sv
module tb_myo_spi_responder;

    localparam int HALF = 5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sck, ss_n, mosi;

    logic        miso, miso_oe, rx_valid, frame_done, frame_error, busy;
    logic [3:0]  tx_index, rx_index;
    logic [15:0] tx_word, rx_word;

    logic        miso1, miso_oe1, rx_valid1, frame_done1, frame_error1, busy1;
    logic [3:0]  tx_index1, rx_index1;
    logic [15:0] tx_word1, rx_word1;

    always #5 clock = ~clock;

    assign tx_word  = 16'hA000 | {12'h000, tx_index};
    assign tx_word1 = 16'hC003;

    myo_spi_responder #(.WORD_BITS(16), .FRAME_WORDS(12), .IDX_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .sck(sck), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_index(tx_index), .tx_word(tx_word),
        .rx_word(rx_word), .rx_index(rx_index), .rx_valid(rx_valid),
        .frame_done(frame_done), .frame_error(frame_error), .busy(busy)
    );

    myo_spi_responder #(.WORD_BITS(16), .FRAME_WORDS(1), .IDX_W(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .sck(sck), .ss_n(ss_n), .mosi(mosi),
        .miso(miso1), .miso_oe(miso_oe1), .tx_index(tx_index1), .tx_word(tx_word1),
        .rx_word(rx_word1), .rx_index(rx_index1), .rx_valid(rx_valid1),
        .frame_done(frame_done1), .frame_error(frame_error1), .busy(busy1)
    );

    // Event recorder; checks happen in the directed sequence below.
    int          rx_cnt = 0, done_cnt = 0, err_cnt = 0, act_cnt = 0;
    int          rx1_cnt = 0, done1_cnt = 0, err1_cnt = 0, act1_cnt = 0;
    logic [15:0] log_word [0:255];
    logic [3:0]  log_idx  [0:255];

    always @(negedge clock) begin
        if (rx_valid) begin
            log_word[rx_cnt[7:0]] <= rx_word;
            log_idx[rx_cnt[7:0]]  <= rx_index;
            rx_cnt <= rx_cnt + 1;
        end
        if (frame_done)          done_cnt  <= done_cnt + 1;
        if (frame_error)         err_cnt   <= err_cnt + 1;
        if (busy || miso_oe)     act_cnt   <= act_cnt + 1;
        if (rx_valid1)           rx1_cnt   <= rx1_cnt + 1;
        if (frame_done1)         done1_cnt <= done1_cnt + 1;
        if (frame_error1)        err1_cnt  <= err1_cnt + 1;
        if (busy1 || miso_oe1)   act1_cnt  <= act1_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rd0 [0:15];
    logic [15:0] rd1 [0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_word(input logic [15:0] w, input int nbits, input int slot);
        rd0[slot] = '0;
        rd1[slot] = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            tick(HALF);
            sck = 1'b1;
            rd0[slot][15-i] = miso;
            rd1[slot][15-i] = miso1;
            tick(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int nwords, input int last_bits, input logic [15:0] base);
        ss_n = 1'b0;
        tick(8);
        for (int k = 0; k < nwords; k++) begin
            spi_word(base + 16'(k), (k == nwords - 1) ? last_bits : 16, k);
        end
        tick(HALF);
        ss_n = 1'b1;
    endtask

    task automatic check_full_frame(input string tag, input int rx0, input int d0, input int e0);
        chk({tag, "_rx_count"}, 32'(rx_cnt - rx0), 32'd12);
        for (int k = 0; k < 12; k++) begin
            chk({tag, "_rx_index"}, {28'h0, log_idx[rx0 + k]}, 32'(k));
            chk({tag, "_rx_word"},  {16'h0, log_word[rx0 + k]}, 32'(k + 1));
            chk({tag, "_miso_word"}, {16'h0, rd0[k]}, 32'h0000A000 | 32'(k));
        end
        chk({tag, "_frame_done"},  32'(done_cnt - d0), 32'd1);
        chk({tag, "_frame_error"}, 32'(err_cnt - e0), 32'd0);
        chk({tag, "_busy_after"},  {31'h0, busy}, 32'd0);
    endtask

    int rx0, d0, e0, a0, r10, d10, e10, a10;

    initial begin
        reset_n = 1'b0;
        sck     = 1'b0;
        ss_n    = 1'b1;
        mosi    = 1'b0;
        tick(3);
        chk("rst_miso",        {31'h0, miso},        32'd0);
        chk("rst_miso_oe",     {31'h0, miso_oe},     32'd0);
        chk("rst_tx_index",    {28'h0, tx_index},    32'd0);
        chk("rst_rx_word",     {16'h0, rx_word},     32'd0);
        chk("rst_rx_index",    {28'h0, rx_index},    32'd0);
        chk("rst_strobes",     {29'h0, rx_valid, frame_done, frame_error}, 32'd0);
        chk("rst_busy",        {31'h0, busy},        32'd0);
        reset_n = 1'b1;
        tick(10);

        // 1: full frame
        rx0 = rx_cnt; d0 = done_cnt; e0 = err_cnt;
        run_frame(12, 16, 16'h0001);
        tick(20);
        check_full_frame("full", rx0, d0, e0);

        // 2: short frame, ss_n rises after 7 bits of word 3
        rx0 = rx_cnt; d0 = done_cnt; e0 = err_cnt;
        run_frame(4, 7, 16'h0001);
        chk("short_oe_before", {31'h0, miso_oe}, 32'd1);
        tick(4);
        chk("short_oe_off", {31'h0, miso_oe}, 32'd0);
        tick(10);
        chk("short_rx_count", 32'(rx_cnt - rx0), 32'd3);
        chk("short_last_idx", {28'h0, log_idx[rx0 + 2]}, 32'd2);
        chk("short_last_word", {16'h0, log_word[rx0 + 2]}, 32'd3);
        chk("short_error", 32'(err_cnt - e0), 32'd1);
        chk("short_done", 32'(done_cnt - d0), 32'd0);

        // 3: overrun, 13 words
        rx0 = rx_cnt; d0 = done_cnt; e0 = err_cnt;
        run_frame(13, 16, 16'h0001);
        tick(20);
        chk("ovr_rx_count", 32'(rx_cnt - rx0), 32'd12);
        chk("ovr_last_idx", {28'h0, log_idx[rx0 + 11]}, 32'd11);
        chk("ovr_word11_miso", {16'h0, rd0[11]}, 32'h0000A00B);
        chk("ovr_word12_miso", {16'h0, rd0[12]}, 32'd0);
        chk("ovr_error", 32'(err_cnt - e0), 32'd1);
        chk("ovr_done", 32'(done_cnt - d0), 32'd0);

        // 4: reset during word 5, released with ss_n low
        ss_n = 1'b0;
        tick(8);
        for (int k = 0; k < 5; k++) spi_word(16'(k + 1), 16, k);
        spi_word(16'h0006, 8, 5);
        chk("mid_busy_before", {31'h0, busy}, 32'd1);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_miso_oe",  {31'h0, miso_oe},     32'd0);
        chk("mid_rst_busy",     {31'h0, busy},        32'd0);
        chk("mid_rst_tx_index", {28'h0, tx_index},    32'd0);
        chk("mid_rst_rx_word",  {16'h0, rx_word},     32'd0);
        chk("mid_rst_rx_index", {28'h0, rx_index},    32'd0);
        tick(3);
        reset_n = 1'b1;
        rx0 = rx_cnt; a0 = act_cnt; e0 = err_cnt; d0 = done_cnt;
        spi_word(16'h00FF, 8, 5);
        spi_word(16'h1234, 16, 6);
        tick(10);
        chk("mid_no_rx",      32'(rx_cnt - rx0),   32'd0);
        chk("mid_no_active",  32'(act_cnt - a0),   32'd0);
        chk("mid_no_strobes", 32'((err_cnt - e0) + (done_cnt - d0)), 32'd0);
        chk("mid_miso",       {31'h0, miso},       32'd0);
        ss_n = 1'b1;
        tick(10);
        rx0 = rx_cnt; d0 = done_cnt; e0 = err_cnt;
        run_frame(12, 16, 16'h0001);
        tick(20);
        check_full_frame("post_rst", rx0, d0, e0);

        // 5: single-word frame on the FRAME_WORDS=1 instance
        r10 = rx1_cnt; d10 = done1_cnt; e10 = err1_cnt;
        run_frame(1, 16, 16'h8001);
        tick(20);
        chk("one_rx_word",  {16'h0, rx_word1}, 32'h00008001);
        chk("one_rx_index", {28'h0, rx_index1}, 32'd0);
        chk("one_miso",     {16'h0, rd1[0]},   32'h0000C003);
        chk("one_rx_count", 32'(rx1_cnt - r10), 32'd1);
        chk("one_done",     32'(done1_cnt - d10), 32'd1);
        chk("one_error",    32'(err1_cnt - e10), 32'd0);

        // 6: sck activity with ss_n high
        rx0 = rx_cnt; d0 = done_cnt; e0 = err_cnt; a0 = act_cnt; a10 = act1_cnt;
        for (int i = 0; i < 10; i++) begin
            mosi = i[0];
            tick(HALF);
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
        tick(10);
        chk("idle_miso_oe", {31'h0, miso_oe}, 32'd0);
        chk("idle_busy",    {31'h0, busy},    32'd0);
        chk("idle_no_rx",   32'(rx_cnt - rx0), 32'd0);
        chk("idle_no_strobes", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        chk("idle_no_active",  32'((act_cnt - a0) + (act1_cnt - a10)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
